// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
//   WORD_W      - data word width.
//   op_e        - access direction, matches the CPU's MemReadWrite encoding.
//   IDLE/WAIT/RESP - responder FSM state codes.
//   word_index  - byte address to RAM word index, upper bits masked off.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Keeps addr[addr_w-1:2]; higher bits alias and addr[1:0] selects a byte.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (addr & mask) >> 2;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word-organised RAM without reset.
//   clock     - write clock, rising edge.
//   we        - write enable.
//   widx      - write word index.
//   wdata     - write data.
//   ridx      - read word index (combinational read).
//   rdata_raw - contents at ridx before any same-edge write.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata_raw
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata_raw = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder with request/ready handshake for the
// multicycle CPU. Writes complete one cycle after acceptance, reads after
// READ_LAT cycles; ready pulses for one cycle in RESP.
//   clock  - system clock, rising edge.
//   reset  - asynchronous, active-high.
//   req    - access request, sampled only while idle.
//   wr     - 0 = read, 1 = write.
//   addr   - byte address; word index is addr[ADDR_W-1:2].
//   wdata  - write data.
//   rdata  - read data, held until the next read completes.
//   ready  - one-cycle completion pulse.
//   busy   - access in progress; requests ignored while high.
//   err    - only with MEM_ALIGN_CHECK_EN defined: misaligned access flag in RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = 4;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] rdata_raw;
  logic [WORD_W-1:0] read_val;
  logic [31:0]       idx_full;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              mis;
  logic              we;
  logic              unused_idx;

  assign idx_full   = word_index(addr, ADDR_W);
  assign idx        = idx_full[IDX_W-1:0];
  assign unused_idx = ^idx_full[31:IDX_W];

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  assign mis = (addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && req;
  assign we       = accept && (wr == MEM_WRITE) && !mis;
  // A misaligned read never looks at the RAM and returns zero.
  assign read_val = mis ? '0 : rdata_raw;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clock     (clock),
    .we        (we),
    .widx      (idx),
    .wdata     (wdata),
    .ridx      (idx),
    .rdata_raw (rdata_raw)
  );

  // Read data is captured at acceptance, so the index and direction need no
  // latch: WAIT is only ever entered by reads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wr == MEM_WRITE) begin
            state_d = RESP;
          end else begin
            data_d = read_val;
            if (READ_LAT == 1) begin
              state_d = RESP;
              rdata_d = read_val;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_W'(READ_LAT - 2);
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = data_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= mis;
    end
  end

  assign err = (state_q == RESP) && mis_q;
`endif

  assign rdata = rdata_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int ADDR_W   = 8;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 2 ** (ADDR_W - 2);

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus the last completed read value.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_r;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .err   (err)
`endif
  );

  // One access: request driven for one cycle (or back-to-back in the current
  // cycle when immediate=1); with hold=1 a write of zero to the same address
  // is presented throughout busy and must be dropped.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit immediate, input bit hold);
    int          lat;
    logic [31:0] exp_r;
    bit          bad;
    if (!immediate) @(negedge clock);
    bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    bad = (a[1:0] != 2'b00);
`endif
    lat   = w ? 1 : READ_LAT;
    exp_r = last_r;
    if (w) begin
      if (!bad) mem_m[a[ADDR_W-1:2]] = d;
    end else begin
      exp_r = bad ? 32'h0 : mem_m[a[ADDR_W-1:2]];
    end
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clock);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clock);
      if (hold) begin
        req = 1'b1; wr = 1'b1; addr = a; wdata = 32'h0;
      end else begin
        req = 1'b0;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy_active a=%h c=%0d got=%b exp=1", a, c, busy);
      end
      checks++;
      if (ready !== 1'(c == lat)) begin
        errors++; $display("FAIL ready_timing a=%h c=%0d got=%b exp=%b", a, c, ready, c == lat);
      end
      checks++;
      if (c == lat) begin
        if (rdata !== exp_r) begin
          errors++; $display("FAIL rdata_resp a=%h w=%b got=%h exp=%h", a, w, rdata, exp_r);
        end
      end else if (rdata !== last_r) begin
        errors++; $display("FAIL rdata_hold_wait a=%h got=%h exp=%h", a, rdata, last_r);
      end
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (err !== 1'((c == lat) && bad)) begin
        errors++; $display("FAIL err_flag a=%h c=%0d got=%b exp=%b", a, c, err, (c == lat) && bad);
      end
`endif
    end
    @(negedge clock);
    req = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL idle_after a=%h got busy=%b ready=%b exp=0/0", a, busy, ready);
    end
    checks++;
    if (rdata !== exp_r) begin
      errors++; $display("FAIL rdata_after a=%h got=%h exp=%h", a, rdata, exp_r);
    end
    last_r = exp_r;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    last_r = 32'h0;
    repeat (2) @(negedge clock);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_state got r=%b b=%b d=%h exp=0/0/0", ready, busy, rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL post_reset got r=%b b=%b d=%h exp=0/0/0", ready, busy, rdata);
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 32'h10, 32'hDEADBEEF, 0, 0);
    access(1'b0, 32'h10, 32'h0, 0, 0);
  endtask

  task automatic test_alias();
    access(1'b1, 32'h104, 32'h12345678, 0, 0);
    access(1'b0, 32'h04, 32'h0, 0, 0);
  endtask

  task automatic test_busy_drop();
    access(1'b0, 32'h10, 32'h0, 0, 1);
    access(1'b0, 32'h10, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clock);
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset got r=%b b=%b d=%h exp=0/0/0", ready, busy, rdata);
    end
    @(negedge clock);
    reset = 1'b0;
    last_r = 32'h0;
    for (int i = 0; i < READ_LAT + 2; i++) begin
      @(negedge clock);
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL no_pulse_after_reset i=%0d got r=%b b=%b exp=0/0", i, ready, busy);
      end
    end
    access(1'b0, 32'h10, 32'h0, 0, 0);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    access(1'b1, 32'h11, 32'hFFFFFFFF, 0, 0);
    access(1'b0, 32'h13, 32'h0, 0, 0);
    access(1'b0, 32'h10, 32'h0, 0, 0);
  endtask
`endif

  task automatic test_back_to_back();
    access(1'b1, 32'h20, 32'hA5A5_0001, 0, 0);
    access(1'b0, 32'h20, 32'h0, 1, 0);
    access(1'b0, 32'h104, 32'h0, 1, 0);
    access(1'b1, 32'h24, 32'h0BAD_F00D, 1, 0);
    access(1'b0, 32'h24, 32'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    // Fill every word so later random reads are all defined.
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom;
      a[ADDR_W-1:2] = i[ADDR_W-3:0];
      a[1:0] = 2'b00;
      access(1'b1, a, $urandom, 0, 0);
    end
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      access(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_busy_drop();
    test_reset_mid_read();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
